// File: rtl/we_pkg.sv
// Shared encodings and width defaults for the WETOP sequencer and the OKTOP status packing.
package we_pkg;
  localparam int RUN_W_DEF = 16;
  localparam int CNT_W_DEF = 32;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CFG       = 3'd1;
  localparam logic [2:0] ST_CFG_WAIT  = 3'd2;
  localparam logic [2:0] ST_TRIG      = 3'd3;
  localparam logic [2:0] ST_TASK_WAIT = 3'd4;
  localparam logic [2:0] ST_GAP       = 3'd5;
  localparam logic [2:0] ST_FLUSH     = 3'd6;
  localparam logic [2:0] ST_ERR       = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_CFG       = ST_CFG,
    S_CFG_WAIT  = ST_CFG_WAIT,
    S_TRIG      = ST_TRIG,
    S_TASK_WAIT = ST_TASK_WAIT,
    S_GAP       = ST_GAP,
    S_FLUSH     = ST_FLUSH,
    S_ERR       = ST_ERR
  } we_state_e;
endpackage

// File: rtl/we_edge_det.sv
// Registers a WETOP status level and flags the cycle after it goes low->high.
module we_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic q, q_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= 1'b0;
      q_d <= 1'b0;
    end else begin
      q   <= d;
      q_d <= q;
    end
  end

  assign rise = q & ~q_d;
endmodule

// File: rtl/we_seq_ctrl.sv
// WETOP measurement scheduler: one config load, N task runs separated by a gap,
// per-phase timeout, progress and error status for the WireOuts.
module we_seq_ctrl
  import we_pkg::*;
#(
  parameter int RUN_W = RUN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             cfg_skip,
  input  logic             flush_en,
  input  logic [RUN_W-1:0] n_runs,
  input  logic [CNT_W-1:0] gap_cycles,
  input  logic [CNT_W-1:0] timeout_cycles,
  input  logic             done_spi,
  input  logic             done_task,
  input  logic             full_ppfifo,
  output logic             trigger_config,
  output logic             trigger_task,
  output logic             force_flip,
  output logic             busy,
  output logic             seq_done,
  output logic             err_timeout,
  output logic [RUN_W-1:0] run_cnt,
  output logic [RUN_W-1:0] full_cnt,
  output logic [2:0]       state
);
  we_state_e        st;
  logic             spi_e, task_e, full_e;
  logic [RUN_W-1:0] n_lat;
  logic             flush_lat;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [RUN_W-1:0] run_inc;
  logic             to_hit;

  we_edge_det u_spi  (.clk(clk), .rst_n(rst_n), .d(done_spi),    .rise(spi_e));
  we_edge_det u_task (.clk(clk), .rst_n(rst_n), .d(done_task),   .rise(task_e));
  we_edge_det u_full (.clk(clk), .rst_n(rst_n), .d(full_ppfifo), .rise(full_e));

  // one counter serves both the wait timeout and the gap, they never overlap
  assign cnt_inc = cnt + CNT_W'(1);
  assign run_inc = run_cnt + RUN_W'(1);
  assign to_hit  = (timeout_cycles != '0) && (cnt_inc == timeout_cycles);
  assign state   = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st             <= S_IDLE;
      busy           <= 1'b0;
      trigger_config <= 1'b0;
      trigger_task   <= 1'b0;
      force_flip     <= 1'b0;
      seq_done       <= 1'b0;
      err_timeout    <= 1'b0;
      run_cnt        <= '0;
      n_lat          <= '0;
      flush_lat      <= 1'b0;
      cnt            <= '0;
    end else begin
      trigger_config <= 1'b0;
      trigger_task   <= 1'b0;
      force_flip     <= 1'b0;
      seq_done       <= 1'b0;
      if (abort) begin
        st   <= S_IDLE;
        busy <= 1'b0;
      end else begin
        case (st)
          S_IDLE, S_ERR: if (start) begin
            n_lat       <= n_runs;
            flush_lat   <= flush_en;
            run_cnt     <= '0;
            err_timeout <= 1'b0;
            cnt         <= '0;
            if (n_runs == '0) begin
              st       <= S_IDLE;
              busy     <= 1'b0;
              seq_done <= 1'b1;
            end else if (cfg_skip) begin
              st           <= S_TRIG;
              busy         <= 1'b1;
              trigger_task <= 1'b1;
            end else begin
              st             <= S_CFG;
              busy           <= 1'b1;
              trigger_config <= 1'b1;
            end
          end
          S_CFG: begin
            st  <= S_CFG_WAIT;
            cnt <= '0;
          end
          S_CFG_WAIT: begin
            if (spi_e) begin
              st           <= S_TRIG;
              trigger_task <= 1'b1;
            end else if (to_hit) begin
              st          <= S_ERR;
              err_timeout <= 1'b1;
            end else cnt <= cnt_inc;
          end
          S_TRIG: begin
            st  <= S_TASK_WAIT;
            cnt <= '0;
          end
          S_TASK_WAIT: begin
            if (task_e) begin
              run_cnt <= run_inc;
              if (run_inc == n_lat) begin
                seq_done <= 1'b1;
                if (flush_lat) begin
                  st         <= S_FLUSH;
                  force_flip <= 1'b1;
                end else begin
                  st   <= S_IDLE;
                  busy <= 1'b0;
                end
              end else begin
                st  <= S_GAP;
                cnt <= '0;
              end
            end else if (to_hit) begin
              st          <= S_ERR;
              err_timeout <= 1'b1;
            end else cnt <= cnt_inc;
          end
          // stays gap_cycles+1 cycles so done->trigger spacing is gap_cycles+3
          S_GAP: begin
            if (cnt >= gap_cycles) begin
              st           <= S_TRIG;
              trigger_task <= 1'b1;
            end else cnt <= cnt_inc;
          end
          S_FLUSH: begin
            st   <= S_IDLE;
            busy <= 1'b0;
          end
          default: begin
            st   <= S_IDLE;
            busy <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) full_cnt <= '0;
    else if ((st == S_IDLE || st == S_ERR) && start && !abort) full_cnt <= '0;
    else if (st != S_IDLE && full_e && full_cnt != '1) full_cnt <= full_cnt + RUN_W'(1);
  end
endmodule

// File: doc/we_seq_ctrl.md
# we_seq_ctrl

Autonomous measurement scheduler for the WETOP core in the 512 kHz `weClk` domain. It sits between the FrontPanel trigger/wire decode and WETOP's `trigger_config` / `trigger_task` / `force_flip` inputs. It runs one configuration load followed by N task runs, separated by a programmable gap. It watches `done_spi`, `done_task` and `full_ppfifo`, enforces a per-phase timeout, and reports progress and error status to WireOuts.

## Interface
Parameters:
- `RUN_W`, 16, width of run count and run counter
- `CNT_W`, 32, width of gap and timeout counters

Ports:
- `clk`  in  1  `weClk`, 512 kHz; all logic on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse, begins a sequence; ignored unless state is IDLE
- `abort`  in  1  one-cycle pulse, returns to IDLE from any state
- `cfg_skip`  in  1  sampled at `start`; 1 skips the configuration phase
- `flush_en`  in  1  sampled at `start`; 1 issues a `force_flip` after the last run
- `n_runs`  in  RUN_W  task runs per sequence; sampled at `start`
- `gap_cycles`  in  CNT_W  idle clocks between task completion and the next trigger
- `timeout_cycles`  in  CNT_W  max clocks to wait for a done; 0 disables the timeout
- `done_spi`  in  1  WETOP config-done level
- `done_task`  in  1  WETOP task-done level
- `full_ppfifo`  in  1  WETOP ping-pong FIFO full level
- `trigger_config`  out  1  one-cycle pulse to WETOP
- `trigger_task`  out  1  one-cycle pulse to WETOP
- `force_flip`  out  1  one-cycle pulse to WETOP
- `busy`  out  1  high in every state except IDLE
- `seq_done`  out  1  one-cycle pulse when a sequence completes normally
- `err_timeout`  out  1  sticky; cleared by `start` or reset
- `run_cnt`  out  RUN_W  completed task runs in the current or last sequence
- `full_cnt`  out  RUN_W  `full_ppfifo` rising edges since `start`; saturates
- `state`  out  3  current state encoding, for debug WireOut

## Operation
- `done_spi`, `done_task` and `full_ppfifo` are registered once. Only rising edges (current & ~previous) are used. Levels that are already high when a wait begins do not satisfy that wait.
- States: IDLE=0, CFG=1, CFG_WAIT=2, TRIG=3, TASK_WAIT=4, GAP=5, FLUSH=6, ERR=7.
- IDLE, on `start`:
  - latch `n_runs`, `cfg_skip`, `flush_en`
  - clear `run_cnt`, `full_cnt`, `err_timeout`
  - if `n_runs`==0: pulse `seq_done` next cycle and stay in IDLE
  - otherwise go to CFG, or to TRIG if `cfg_skip`
- CFG: pulse `trigger_config` for one cycle, then go to CFG_WAIT.
- CFG_WAIT: on a `done_spi` edge, go to TRIG.
- TRIG: pulse `trigger_task` for one cycle, then go to TASK_WAIT.
- TASK_WAIT: on a `done_task` edge:
  - increment `run_cnt`
  - if `run_cnt`+1 == latched n_runs: go to FLUSH if `flush_en`, else pulse `seq_done` and go to IDLE
  - otherwise go to GAP
- GAP: count `gap_cycles`, then go to TRIG. `gap_cycles`==0 goes straight to TRIG on the next cycle.
- FLUSH: pulse `force_flip` for one cycle, pulse `seq_done`, go to IDLE.
- Timeout in CFG_WAIT and TASK_WAIT:
  - a wait counter clears on entry and increments each cycle
  - when it reaches `timeout_cycles` (nonzero), set `err_timeout` and go to ERR
- ERR: hold until `start` (clears the error and begins a new sequence) or `abort` (go to IDLE, `err_timeout` kept).
- `abort`: from any state, go to IDLE next cycle. No `seq_done`, no trigger pulses. Counters hold their values.
- Simultaneous events:
  - `abort` with `start`: `abort` wins
  - done edge on the same cycle the timeout expires: the done edge wins
  - `full_ppfifo` edges are counted in every non-IDLE state, including during `abort`
- `full_cnt` saturates at all ones. `run_cnt` cannot exceed the latched n_runs.

## Timing
- Reset values: state IDLE; all pulse outputs 0; `busy`=0, `err_timeout`=0, `run_cnt`=0, `full_cnt`=0, `state`=0.
- `start` at cycle 0 puts the block in CFG at cycle 1 with `trigger_config`=1 during cycle 1. All outputs are registered.
- A `done_spi` rising at the input at cycle k is seen at k+1 (register plus edge detect). TRIG is entered at k+2 and `trigger_task` is high in that cycle.
- Task-to-task spacing from a `done_task` input edge to the next `trigger_task` is `gap_cycles` + 3 clocks.
- `seq_done` and the final `run_cnt` update occur on the same clock edge.
- Reset mid-sequence clears everything asynchronously. No pulse is emitted on reset release.

## Structure
- Shared package `we_pkg`: state encoding localparams (IDLE…ERR) and the `RUN_W`/`CNT_W` defaults. The OKTOP-level status packing reuses them.
- One sub-module `we_edge_det`: a registered rising-edge detector with active-low async reset, instantiated three times.
- The FSM, gap/timeout counters and status registers stay in `we_seq_ctrl`.

## Test plan
- `n_runs`=3, `cfg_skip`=0, `gap_cycles`=4, done edges returned after 10 clocks → 1 `trigger_config`, 3 `trigger_task` pulses spaced 17 clocks apart, `run_cnt`=3, one `seq_done`, no `force_flip`.
- `n_runs`=2, `cfg_skip`=1, `flush_en`=1 → no `trigger_config`, 2 task pulses, `force_flip` and `seq_done` together one cycle after the 2nd done edge is seen.
- `timeout_cycles`=20, `done_task` never rises → `err_timeout`=1 exactly 20 clocks after entering TASK_WAIT, state=7; a subsequent `start` clears the error and restarts.
- `abort` during GAP with `run_cnt`=1 → IDLE next cycle, `run_cnt` stays 1, no further triggers, no `seq_done`.
- `done_task` held high before `start`, `n_runs`=1 → TASK_WAIT does not complete until a fresh low→high edge arrives. Separately, `n_runs`=0 → immediate `seq_done`, `busy` never asserted.
- Five `full_ppfifo` pulses during a run → `full_cnt`=5; with `RUN_W` overridden to 2, eight pulses leave `full_cnt` saturated at 3.
